// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 512-bit block into a 16-word sliding window
// and emits W_0..W_{ROUNDS-1}, one word per step, with its round index.
module sha256_msg_sched #(
    parameter int ROUNDS = 64,
    parameter int IDX_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    input  logic             step,
    output logic             w_valid,
    output logic [31:0]      w_out,
    output logic [IDX_W-1:0] w_idx,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    state_t           state_q, state_d;
    logic [31:0]      win_q [16];
    logic [31:0]      win_d [16];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (abort) begin
            // Flush discards the partial schedule and any accept or step this cycle.
            state_d = IDLE;
            idx_d   = '0;
            for (int i = 0; i < 16; i++) win_d[i] = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) win_d[i] = blk_data[511-32*i -: 32];
                        idx_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (step) begin
                        for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
                        // win[0] is W_t, so this produces W_{t+16}.
                        win_d[15] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
        end
    end

    assign blk_ready = (state_q == IDLE);
    assign w_valid   = (state_q == RUN);
    assign w_out     = win_q[0];
    assign w_idx     = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: directed sequence with random blocks and stalls,
// checked against a whole-array reference of the SHA-256 schedule recurrence.
module tb_sha256_msg_sched;

    logic         clk = 1'b0;
    logic         rst, abort, blk_valid, step;
    logic [511:0] blk_data;
    logic         blk_ready, w_valid, done;
    logic [31:0]  w_out;
    logic [6:0]   w_idx;

    logic         abort17, blk_valid17, step17;
    logic [511:0] blk_data17;
    logic         blk_ready17, w_valid17, done17;
    logic [31:0]  w_out17;
    logic [6:0]   w_idx17;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]  ref_w [64];
    logic [31:0]  abc_exp [20];
    logic [511:0] abc_blk, b1, b2;

    always #5 clk = ~clk;

    sha256_msg_sched #(.ROUNDS(64), .IDX_W(7)) dut (
        .clk(clk), .rst(rst), .abort(abort), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .blk_data(blk_data), .step(step),
        .w_valid(w_valid), .w_out(w_out), .w_idx(w_idx), .done(done)
    );

    sha256_msg_sched #(.ROUNDS(17), .IDX_W(7)) dut17 (
        .clk(clk), .rst(rst), .abort(abort17), .blk_valid(blk_valid17),
        .blk_ready(blk_ready17), .blk_data(blk_data17), .step(step17),
        .w_valid(w_valid17), .w_out(w_out17), .w_idx(w_idx17), .done(done17)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_ref(input logic [511:0] b);
        for (int t = 0; t < 16; t++) ref_w[t] = b[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            ref_w[t] = s1(ref_w[t-2]) + ref_w[t-7] + s0(ref_w[t-15]) + ref_w[t-16];
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Checks n consecutive words starting at t=0 with step held high by the caller.
    task automatic stream(input int n, input bit abc);
        for (int t = 0; t < n; t++) begin
            chk($sformatf("w_valid[%0d]", t), {31'b0, w_valid}, 32'd1);
            chk($sformatf("w_idx[%0d]", t), {25'b0, w_idx}, t);
            chk($sformatf("w_out[%0d]", t), w_out, ref_w[t]);
            chk($sformatf("blk_ready_run[%0d]", t), {31'b0, blk_ready}, 32'd0);
            chk($sformatf("done_run[%0d]", t), {31'b0, done}, 32'd0);
            if (abc && t < 20) chk($sformatf("abc_w[%0d]", t), w_out, abc_exp[t]);
            tick();
        end
    endtask

    task automatic chk_done_cycle(input string tag);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_valid"}, {31'b0, w_valid}, 32'd0);
        chk({tag, "_idx"}, {25'b0, w_idx}, 32'd0);
        chk({tag, "_ready"}, {31'b0, blk_ready}, 32'd1);
    endtask

    task automatic accept(input logic [511:0] b);
        blk_data  = b;
        blk_valid = 1'b1;
        tick();
        blk_valid = 1'b0;
    endtask

    initial begin
        int t, guard;
        bit s;

        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        for (int i = 0; i < 20; i++) abc_exp[i] = 32'h0;
        abc_exp[0]  = 32'h61626380;
        abc_exp[15] = 32'h00000018;
        abc_exp[16] = 32'h61626380;
        abc_exp[17] = 32'h000F0000;
        abc_exp[18] = 32'h7DA86405;
        abc_exp[19] = 32'h600003C6;

        rst = 1'b1; abort = 1'b0; blk_valid = 1'b0; step = 1'b0; blk_data = '0;
        abort17 = 1'b0; blk_valid17 = 1'b0; step17 = 1'b0; blk_data17 = '0;
        tick();
        tick();
        chk("rst_ready", {31'b0, blk_ready}, 32'd1);
        chk("rst_valid", {31'b0, w_valid}, 32'd0);
        chk("rst_out", w_out, 32'd0);
        chk("rst_idx", {25'b0, w_idx}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // abc block with step held high
        compute_ref(abc_blk);
        step = 1'b1;
        accept(abc_blk);
        stream(64, 1'b1);
        chk_done_cycle("abc");
        step = 1'b0;
        tick();
        chk("abc_done_pulse", {31'b0, done}, 32'd0);

        // abc block with random stalls
        accept(abc_blk);
        t = 0;
        guard = 0;
        while (t < 64 && guard < 2000) begin
            chk($sformatf("stall_valid[%0d]", t), {31'b0, w_valid}, 32'd1);
            chk($sformatf("stall_idx[%0d]", t), {25'b0, w_idx}, t);
            chk($sformatf("stall_out[%0d]", t), w_out, ref_w[t]);
            chk($sformatf("stall_done[%0d]", t), {31'b0, done}, 32'd0);
            s = ($urandom_range(0, 2) != 0);
            step = s;
            tick();
            if (s) t++;
            guard++;
        end
        chk("stall_words", t, 32'd64);
        chk_done_cycle("stall");
        step = 1'b0;
        tick();
        chk("stall_done_pulse", {31'b0, done}, 32'd0);

        // back-to-back: block 2 held valid through RUN, taken in the done cycle
        rand_block(b1);
        rand_block(b2);
        compute_ref(b1);
        step = 1'b1;
        accept(b1);
        blk_data  = b2;
        blk_valid = 1'b1;
        stream(64, 1'b0);
        chk_done_cycle("b2b1");
        compute_ref(b2);
        tick();
        blk_valid = 1'b0;
        stream(64, 1'b0);
        chk_done_cycle("b2b2");
        step = 1'b0;
        tick();

        // abort at w_idx=30 with step high
        rand_block(b1);
        compute_ref(b1);
        step = 1'b1;
        accept(b1);
        stream(30, 1'b0);
        chk("abort_at_idx", {25'b0, w_idx}, 32'd30);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        step  = 1'b0;
        chk("abort_valid", {31'b0, w_valid}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_ready", {31'b0, blk_ready}, 32'd1);
        chk("abort_idx", {25'b0, w_idx}, 32'd0);
        // abort wins over a simultaneous accept
        abort     = 1'b1;
        blk_valid = 1'b1;
        blk_data  = b1;
        tick();
        abort     = 1'b0;
        blk_valid = 1'b0;
        chk("abort_acc_valid", {31'b0, w_valid}, 32'd0);
        chk("abort_acc_ready", {31'b0, blk_ready}, 32'd1);
        rand_block(b2);
        compute_ref(b2);
        accept(b2);
        step = 1'b1;
        stream(64, 1'b0);
        chk_done_cycle("post_abort");
        step = 1'b0;
        tick();

        // rst at w_idx=63 together with step
        rand_block(b1);
        compute_ref(b1);
        step = 1'b1;
        accept(b1);
        stream(63, 1'b0);
        chk("rst63_idx", {25'b0, w_idx}, 32'd63);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        step = 1'b0;
        chk("rst63_done", {31'b0, done}, 32'd0);
        chk("rst63_valid", {31'b0, w_valid}, 32'd0);
        chk("rst63_out", w_out, 32'd0);
        chk("rst63_idx0", {25'b0, w_idx}, 32'd0);
        chk("rst63_ready", {31'b0, blk_ready}, 32'd1);
        tick();
        chk("rst63_done_late", {31'b0, done}, 32'd0);

        // ROUNDS=17 instance
        rand_block(b1);
        compute_ref(b1);
        step17      = 1'b1;
        blk_data17  = b1;
        blk_valid17 = 1'b1;
        tick();
        blk_valid17 = 1'b0;
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("r17_valid[%0d]", k), {31'b0, w_valid17}, 32'd1);
            chk($sformatf("r17_idx[%0d]", k), {25'b0, w_idx17}, k);
            chk($sformatf("r17_out[%0d]", k), w_out17, ref_w[k]);
            chk($sformatf("r17_done[%0d]", k), {31'b0, done17}, 32'd0);
            tick();
        end
        step17 = 1'b0;
        chk("r17_end_done", {31'b0, done17}, 32'd1);
        chk("r17_end_valid", {31'b0, w_valid17}, 32'd0);
        chk("r17_end_ready", {31'b0, blk_ready17}, 32'd1);
        chk("r17_end_idx", {25'b0, w_idx17}, 32'd0);
        tick();
        chk("r17_done_pulse", {31'b0, done17}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
